axi_lite_buf: RTL
=================

Name: axi_lite_buf

Overview:
- Parametrised AXI-Lite channel connector with per-channel buffering; the successor to a plain wire join.
- Each of the five channels (AW, W, B, AR, R) is independently either a wire-through or an N-entry registered FIFO.
- Used to break timing paths and absorb bursts between interconnect stages.
- Both sides are axi_lite_channel interfaces; ADDR_WIDTH/DATA_WIDTH mismatch between them is a $fatal elaboration error.

Parameters:
- AW_DEPTH, 2, AW buffer entries; 0 = wire-through.
- W_DEPTH, 2, W buffer entries; 0 = wire-through.
- B_DEPTH, 2, B buffer entries; 0 = wire-through.
- AR_DEPTH, 2, AR buffer entries; 0 = wire-through.
- R_DEPTH, 2, R buffer entries; 0 = wire-through.

Ports:
- clk  input  1  clock; all state on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- master  axi_lite_channel.slave  iface  upstream side; AW/W/AR/B-ready/R-ready inbound.
- slave  axi_lite_channel.master  iface  downstream side.

Behaviour:
- Reset is asynchronous and active-low, named rstn; one clock, clk.
- Depth 0 channel: payload, valid and ready are assigned straight through, with zero latency and no state.
- Depth N>=1 channel is a FIFO of N entries; each entry holds the packed payload:
  - AW/AR: addr+prot.
  - W: data+strb.
  - B: resp.
  - R: data+resp.
- State per FIFO:
  - rd_ptr, wr_ptr, each $clog2(N) bits (min 1).
  - count, $clog2(N+1) bits.
- Pointers wrap from N-1 to 0; non-power-of-2 N is legal.
- Push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != N), driven from a registered not-full flag; no combinational ready path from the output side.
- out_valid = (count != 0), from a registered flag; out payload = mem[rd_ptr], a register read.
- Latency: push in cycle t makes the entry visible on out_valid in cycle t+1.
- Throughput:
  - N>=2: 1 beat/cycle sustained.
  - N=1: 1 beat per 2 cycles (push and pop never in the same cycle when full).
- Simultaneous push and pop:
  - With 0<count<N: count unchanged, both pointers advance.
  - With count==0: push only (no pop possible).
  - With count==N: push blocked by in_ready=0; pop proceeds.
- Output payload holds stable while out_valid && !out_ready (AXI rule).
- Reset values, asserted asynchronously while rstn=0:
  - All FIFO valids 0 and all FIFO in_ready 0; count 0, pointers 0.
  - in_ready rises in the first clk edge after rstn deasserts.
  - Memory contents are not reset.
- Reset mid-operation drops all buffered beats with no completion generated; the surrounding system resets both sides together.
- No reordering, and no coupling between channels: AW and W are buffered independently, and B/R ordering is preserved per channel.
- Wire-through channels are unaffected by rstn.

Decomposition:
- axi_lite_pkg: resp_t (OKAY/EXOKAY/SLVERR/DECERR enum, 2 bits) and prot_t (3 bits).
  - Payload packing is local, since widths are interface-parameter dependent.
- Sub-module axi_lite_buf_fifo (WIDTH, DEPTH; clk, rstn, in_data/in_valid/in_ready, out_data/out_valid/out_ready).
  - Instantiated five times inside generate blocks; DEPTH==0 selects plain assigns.

Test Plan:
- Reset: hold rstn=0 with master.aw_valid=1 -> slave.aw_valid=0 and master.aw_ready=0; after release, master.aw_ready=1 on the first edge.
- Depth 2 AW streaming: 8 back-to-back writes, addr 0x00..0x1C, slave.aw_ready=1 -> each addr appears on slave.aw_addr one cycle later, one per cycle, no gaps.
- Backpressure on W (depth 2): slave.w_ready=0, push data 0xA1, 0xA2, 0xA3 -> master.w_ready drops after 2 accepts. Then w_ready=1 -> 0xA1, 0xA2 emerge in order and 0xA3 is accepted once space frees.
- Depth 1 R channel, continuous slave.r_valid with r_data incrementing -> accept every other cycle; master receives the sequence intact with resp preserved (e.g. SLVERR=2'b10 on beat 3).
- Depth 0 on AR: slave.ar_ready toggled -> master.ar_ready follows it in the same cycle, and ar_addr 0x40 passes combinationally.
- Mid-operation reset: B FIFO holding 2 responses, rstn pulsed low between edges -> master.b_valid falls immediately; after release, count is 0 and no stale response is emitted.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types for the channel buffer.
// Payload packing stays local to the users.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef logic [2:0] prot_t;

    localparam int PROT_W = 3;
    localparam int RESP_W = 2;

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite five-channel bundle.
// master drives requests, slave drives responses.
interface axi_lite_channel
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import axi_lite_pkg::*;

    logic [ADDR_WIDTH-1:0]   aw_addr;
    prot_t                   aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;

    resp_t                   b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ADDR_WIDTH-1:0]   ar_addr;
    prot_t                   ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [DATA_WIDTH-1:0]   r_data;
    resp_t                   r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_addr, ar_prot, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_addr, aw_prot, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_valid,
        output w_ready,
        output b_resp, b_valid,
        input  b_ready,
        input  ar_addr, ar_prot, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_lite_buf_fifo.sv
// Registered N-entry FIFO for one AXI-Lite channel.
// Ready and valid both come straight from flops.
module axi_lite_buf_fifo
    import axi_lite_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int MD = (DEPTH > 1) ? DEPTH : 2;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [MD];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             not_full_q, not_full_d;
    logic             not_empty_q, not_empty_d;
    logic             push, pop;

    assign push      = in_valid && not_full_q;
    assign pop       = not_empty_q && out_ready;
    assign in_ready  = not_full_q;
    assign out_valid = not_empty_q;
    assign out_data  = mem_q[rd_ptr_q];

    // Next pointers, occupancy and registered flags.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        not_full_d  = (count_d != FULL);
        not_empty_d = (count_d != '0);
    end

    // Control state; ready stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            not_full_q  <= 1'b0;
            not_empty_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            not_full_q  <= not_full_d;
            not_empty_q <= not_empty_d;
        end
    end

    // Storage is left unreset; flags guard every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/axi_lite_buf.sv
// AXI-Lite connector with per-channel FIFO or wire join.
// Depth 0 on a channel gives a stateless pass-through.
module axi_lite_buf
    import axi_lite_pkg::*;
#(
    parameter int AW_DEPTH = 2,
    parameter int W_DEPTH  = 2,
    parameter int B_DEPTH  = 2,
    parameter int AR_DEPTH = 2,
    parameter int R_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rstn,
    axi_lite_channel.slave  master,
    axi_lite_channel.master slave
);

    localparam int AWID = $bits(master.aw_addr);
    localparam int DWID = $bits(master.w_data);
    localparam int SWID = DWID / 8;
    localparam int AXW  = AWID + PROT_W;
    localparam int WW   = DWID + SWID;
    localparam int RW   = DWID + RESP_W;

    if (AWID != $bits(slave.aw_addr) ||
        DWID != $bits(slave.w_data)) begin : g_width_err
        $fatal(1, "axi_lite_buf: side widths differ");
    end

    if (AW_DEPTH == 0) begin : g_aw_wire
        assign slave.aw_addr   = master.aw_addr;
        assign slave.aw_prot   = master.aw_prot;
        assign slave.aw_valid  = master.aw_valid;
        assign master.aw_ready = slave.aw_ready;
    end else begin : g_aw_fifo
        logic [AXW-1:0] out_d;
        axi_lite_buf_fifo #(.WIDTH(AXW), .DEPTH(AW_DEPTH)) u_fifo (
            .clk      (clk),
            .rstn     (rstn),
            .in_data  ({master.aw_addr, master.aw_prot}),
            .in_valid (master.aw_valid),
            .in_ready (master.aw_ready),
            .out_data (out_d),
            .out_valid(slave.aw_valid),
            .out_ready(slave.aw_ready)
        );
        assign {slave.aw_addr, slave.aw_prot} = out_d;
    end

    if (W_DEPTH == 0) begin : g_w_wire
        assign slave.w_data   = master.w_data;
        assign slave.w_strb   = master.w_strb;
        assign slave.w_valid  = master.w_valid;
        assign master.w_ready = slave.w_ready;
    end else begin : g_w_fifo
        logic [WW-1:0] out_d;
        axi_lite_buf_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_fifo (
            .clk      (clk),
            .rstn     (rstn),
            .in_data  ({master.w_data, master.w_strb}),
            .in_valid (master.w_valid),
            .in_ready (master.w_ready),
            .out_data (out_d),
            .out_valid(slave.w_valid),
            .out_ready(slave.w_ready)
        );
        assign {slave.w_data, slave.w_strb} = out_d;
    end

    if (B_DEPTH == 0) begin : g_b_wire
        assign master.b_resp  = slave.b_resp;
        assign master.b_valid = slave.b_valid;
        assign slave.b_ready  = master.b_ready;
    end else begin : g_b_fifo
        logic [RESP_W-1:0] out_d;
        axi_lite_buf_fifo #(.WIDTH(RESP_W), .DEPTH(B_DEPTH)) u_fifo (
            .clk      (clk),
            .rstn     (rstn),
            .in_data  (slave.b_resp),
            .in_valid (slave.b_valid),
            .in_ready (slave.b_ready),
            .out_data (out_d),
            .out_valid(master.b_valid),
            .out_ready(master.b_ready)
        );
        assign master.b_resp = resp_t'(out_d);
    end

    if (AR_DEPTH == 0) begin : g_ar_wire
        assign slave.ar_addr   = master.ar_addr;
        assign slave.ar_prot   = master.ar_prot;
        assign slave.ar_valid  = master.ar_valid;
        assign master.ar_ready = slave.ar_ready;
    end else begin : g_ar_fifo
        logic [AXW-1:0] out_d;
        axi_lite_buf_fifo #(.WIDTH(AXW), .DEPTH(AR_DEPTH)) u_fifo (
            .clk      (clk),
            .rstn     (rstn),
            .in_data  ({master.ar_addr, master.ar_prot}),
            .in_valid (master.ar_valid),
            .in_ready (master.ar_ready),
            .out_data (out_d),
            .out_valid(slave.ar_valid),
            .out_ready(slave.ar_ready)
        );
        assign {slave.ar_addr, slave.ar_prot} = out_d;
    end

    if (R_DEPTH == 0) begin : g_r_wire
        assign master.r_data  = slave.r_data;
        assign master.r_resp  = slave.r_resp;
        assign master.r_valid = slave.r_valid;
        assign slave.r_ready  = master.r_ready;
    end else begin : g_r_fifo
        logic [RW-1:0] out_d;
        axi_lite_buf_fifo #(.WIDTH(RW), .DEPTH(R_DEPTH)) u_fifo (
            .clk      (clk),
            .rstn     (rstn),
            .in_data  ({slave.r_data, slave.r_resp}),
            .in_valid (slave.r_valid),
            .in_ready (slave.r_ready),
            .out_data (out_d),
            .out_valid(master.r_valid),
            .out_ready(master.r_ready)
        );
        assign master.r_data = out_d[RW-1:RESP_W];
        assign master.r_resp = resp_t'(out_d[RESP_W-1:0]);
    end

endmodule
